// File: rtl/neuron_update_scheduler_if.sv
// Handshake/bus bundle between neuron_update_scheduler (master) and its environment:
// tick control, ping-pong register file port, update unit port and spike stream.
interface neuron_update_scheduler_if #(
    parameter int NR_WIDTH = 56,
    parameter int AW       = 4
);
    logic                step_start;
    logic                freeze;
    logic                busy;
    logic                step_done;
    logic                overrun;
    logic                time_index;
    logic [AW:0]         nr_addr;
    logic                nr_re;
    logic [NR_WIDTH-1:0] nr_rdata;
    logic                nr_we;
    logic [NR_WIDTH-1:0] nr_wdata;
    logic                upd_valid;
    logic [NR_WIDTH-1:0] upd_state;
    logic [NR_WIDTH-1:0] upd_result;
    logic                upd_spike;
    logic                spk_valid;
    logic [AW-1:0]       spk_idx;
    logic                spk_ready;
`ifdef NUS_SPIKE_COUNT_EN
    logic [AW:0]         spike_count;
`endif

    modport master (
`ifdef NUS_SPIKE_COUNT_EN
        output spike_count,
`endif
        input  step_start, freeze, nr_rdata, upd_result, upd_spike, spk_ready,
        output busy, step_done, overrun, time_index, nr_addr, nr_re, nr_we, nr_wdata,
        output upd_valid, upd_state, spk_valid, spk_idx
    );

    modport slave (
`ifdef NUS_SPIKE_COUNT_EN
        input  spike_count,
`endif
        output step_start, freeze, nr_rdata, upd_result, upd_spike, spk_ready,
        input  busy, step_done, overrun, time_index, nr_addr, nr_re, nr_we, nr_wdata,
        input  upd_valid, upd_state, spk_valid, spk_idx
    );
endinterface

// File: rtl/neuron_update_scheduler.sv
// Runs one timestep of neuron updates over a two-bank register file: read, update, write back, spike.
// Define NUS_SPIKE_COUNT_EN to add the spike_count output (spikes emitted in the last completed step).
module neuron_update_scheduler #(
    parameter int NR_WIDTH = 56,
    parameter int NR_DEPTH = 16,
    parameter int UPD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    neuron_update_scheduler_if.master bus
);
    localparam int AW = $clog2(NR_DEPTH);
    localparam int LW = (UPD_LAT > 1) ? $clog2(UPD_LAT) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NR_DEPTH - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(UPD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_EMIT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t        state_r;
    logic [AW-1:0] index_r;
    logic [LW-1:0] lat_cnt_r;
    logic          pending_r;
    logic          busy_r;
    logic          step_done_r;
    logic          overrun_r;
    logic          time_index_r;
    logic [AW:0]   nr_addr_r;
    logic          nr_re_r;
    logic          nr_we_r;
    logic          upd_valid_r;
    logic          spk_valid_r;
    logic [AW-1:0] spk_idx_r;

    logic          start_s;
    logic          advance_s;
    logic          last_s;
    logic [AW-1:0] idx_inc_s;

    // Step launch (possibly deferred by freeze) and completion of the current neuron
    always_comb begin
        start_s   = 1'b0;
        advance_s = 1'b0;
        last_s    = (index_r == LAST_IDX);
        idx_inc_s = index_r + AW'(1);
        if (state_r == ST_IDLE) begin
            start_s = (bus.step_start || pending_r) && !bus.freeze;
        end else if (state_r == ST_WRITE) begin
            advance_s = !bus.upd_spike;
        end else if (state_r == ST_EMIT) begin
            advance_s = bus.spk_ready;
        end else begin
            advance_s = 1'b0;
        end
    end

    // Timestep FSM; strobes are registered so they line up exactly with their state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            index_r      <= '0;
            lat_cnt_r    <= '0;
            pending_r    <= 1'b0;
            busy_r       <= 1'b0;
            step_done_r  <= 1'b0;
            overrun_r    <= 1'b0;
            time_index_r <= 1'b0;
            nr_addr_r    <= '0;
            nr_re_r      <= 1'b0;
            nr_we_r      <= 1'b0;
            upd_valid_r  <= 1'b0;
            spk_valid_r  <= 1'b0;
            spk_idx_r    <= '0;
        end else begin
            nr_re_r     <= 1'b0;
            nr_we_r     <= 1'b0;
            upd_valid_r <= 1'b0;
            step_done_r <= 1'b0;
            nr_addr_r   <= '0;

            if (bus.step_start && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r   <= ST_READ;
                        index_r   <= '0;
                        pending_r <= 1'b0;
                        busy_r    <= 1'b1;
                        nr_re_r   <= 1'b1;
                        nr_addr_r <= {time_index_r, {AW{1'b0}}};
                    end else if (bus.step_start) begin
                        pending_r <= 1'b1;
                    end
                end
                ST_READ: begin
                    state_r     <= ST_EVAL;
                    upd_valid_r <= 1'b1;
                    lat_cnt_r   <= '0;
                end
                ST_EVAL: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        state_r   <= ST_WRITE;
                        nr_we_r   <= 1'b1;
                        nr_addr_r <= {~time_index_r, index_r};
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LW'(1);
                    end
                end
                ST_WRITE: begin
                    if (bus.upd_spike) begin
                        state_r     <= ST_EMIT;
                        spk_valid_r <= 1'b1;
                        spk_idx_r   <= index_r;
                    end
                end
                ST_EMIT: begin
                    if (bus.spk_ready) begin
                        spk_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!bus.freeze) begin
                        state_r   <= ST_READ;
                        nr_re_r   <= 1'b1;
                        nr_addr_r <= {time_index_r, index_r};
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    time_index_r <= ~time_index_r;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    spk_valid_r <= 1'b0;
                end
            endcase

            // Neuron finished (written back, spike if any accepted): pick what comes next
            if (advance_s) begin
                if (last_s) begin
                    state_r     <= ST_DONE;
                    index_r     <= '0;
                    step_done_r <= 1'b1;
                end else if (bus.freeze) begin
                    state_r <= ST_HOLD;
                    index_r <= idx_inc_s;
                end else begin
                    state_r   <= ST_READ;
                    index_r   <= idx_inc_s;
                    nr_re_r   <= 1'b1;
                    nr_addr_r <= {time_index_r, idx_inc_s};
                end
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.step_done  = step_done_r;
    assign bus.overrun    = overrun_r;
    assign bus.time_index = time_index_r;
    assign bus.nr_addr    = nr_addr_r;
    assign bus.nr_re      = nr_re_r;
    assign bus.nr_we      = nr_we_r;
    assign bus.upd_valid  = upd_valid_r;
    assign bus.spk_valid  = spk_valid_r;
    assign bus.spk_idx    = spk_idx_r;

    // Data words pass straight through, gated so they read as zero outside their strobe
    assign bus.upd_state = upd_valid_r ? bus.nr_rdata : {NR_WIDTH{1'b0}};
    assign bus.nr_wdata  = nr_we_r ? bus.upd_result : {NR_WIDTH{1'b0}};

`ifdef NUS_SPIKE_COUNT_EN
    logic [AW:0] spike_cnt_r;
    logic [AW:0] spike_count_r;

    // Counts accepted spikes in the running step and publishes the total as the step closes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_cnt_r   <= '0;
            spike_count_r <= '0;
        end else begin
            if (start_s) begin
                spike_cnt_r <= '0;
            end else if ((state_r == ST_EMIT) && bus.spk_ready) begin
                spike_cnt_r <= spike_cnt_r + (AW+1)'(1);
            end
            if (state_r == ST_DONE) begin
                spike_count_r <= spike_cnt_r;
            end
        end
    end

    assign bus.spike_count = spike_count_r;
`endif
endmodule
